// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1:N stream demux.
package demux_pkg;
    localparam int DEMUX_NCH_DEF = 8;
    localparam int DEMUX_DW_DEF  = 1;

    // Select width for n channels, never below one bit.
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction
endpackage

// File: rtl/demux_chan_reg.sv
// One-entry valid/ready holding register for a single demux output channel.
module demux_chan_reg #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] ld_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          loadable
);
    // A full register whose word leaves this cycle can take a new one.
    assign loadable = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= ld_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/demux_1_n_stream.sv
// 1:NCH valid/ready demux with per-channel output registers and out-of-range drop flag.
// Optional broadcast input enabled by defining DEMUX_BCAST_EN.
module demux_1_n_stream
    import demux_pkg::*;
#(
    parameter  int NCH  = DEMUX_NCH_DEF,
    parameter  int DW   = DEMUX_DW_DEF,
    localparam int SELW = sel_width(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic [SELW-1:0]   in_sel,
`ifdef DEMUX_BCAST_EN
    input  logic              in_bcast,
`endif
    output logic [NCH-1:0]    out_valid,
    input  logic [NCH-1:0]    out_ready,
    output logic [NCH*DW-1:0] out_data,
    output logic              drop_err
);
    localparam logic [SELW:0] NCH_L = (SELW+1)'(NCH);

    logic           sel_ok;
    logic           bcast;
    logic           xfer;
    logic [NCH-1:0] sel_hit;
    logic [NCH-1:0] loadable;
    logic [NCH-1:0] load;

`ifdef DEMUX_BCAST_EN
    assign bcast = in_valid & in_bcast;
`else
    assign bcast = 1'b0;
`endif

    assign sel_ok = ({1'b0, in_sel} < NCH_L);

    always_comb begin
        sel_hit = '0;
        for (int k = 0; k < NCH; k++)
            sel_hit[k] = (in_sel == SELW'(k));
    end

    // Out-of-range words are always sunk so the producer never stalls on them.
    always_comb begin
        in_ready = 1'b0;
        if (rst)
            in_ready = 1'b0;
        else if (bcast)
            in_ready = &loadable;
        else if (!sel_ok)
            in_ready = 1'b1;
        else
            in_ready = |(sel_hit & loadable);
    end

    assign xfer = in_valid & in_ready;
    assign load = bcast ? {NCH{xfer}} : (sel_hit & {NCH{xfer}});

    always_ff @(posedge clk) begin
        if (rst)
            drop_err <= 1'b0;
        else
            drop_err <= xfer & ~bcast & ~sel_ok;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        demux_chan_reg #(.DW(DW)) u_chan (
            .clk       (clk),
            .rst       (rst),
            .load      (load[k]),
            .ld_data   (in_data),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*DW +: DW]),
            .loadable  (loadable[k])
        );
    end
endmodule

// File: tb/tb_demux_1_n_stream.sv
// Scoreboard bench for demux_1_n_stream: per-channel word queues model the held words.
module tb_demux_1_n_stream;
    localparam int NCH  = 6;
    localparam int DW   = 8;
    localparam int SELW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic [SELW-1:0]   in_sel;
    logic [NCH-1:0]    out_valid;
    logic [NCH-1:0]    out_ready;
    logic [NCH*DW-1:0] out_data;
    logic              drop_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: words owed to each channel, last word loaded, pending drop pulse.
    logic [DW-1:0] q [NCH][$];
    logic [DW-1:0] last [NCH];
    logic          exp_drop = 1'b0;
    logic          mon_en   = 1'b0;
    logic          exp_rdy;
    logic          hv;
    logic          a;

    demux_1_n_stream #(.NCH(NCH), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs to the model, retire words the consumer takes.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst)
                exp_rdy = 1'b0;
            else if (int'(in_sel) >= NCH)
                exp_rdy = 1'b1;
            else
                exp_rdy = (q[in_sel].size() == 0) || out_ready[in_sel];
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("drop_err", 64'(drop_err), 64'(exp_drop));
            for (int k = 0; k < NCH; k++) begin
                hv = (q[k].size() != 0);
                chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(hv));
                if (hv)
                    chk($sformatf("out_data[%0d]", k), 64'(out_data[k*DW +: DW]), 64'(q[k][0]));
                else
                    chk($sformatf("out_data_idle[%0d]", k), 64'(out_data[k*DW +: DW]), 64'(last[k]));
                if (hv && out_valid[k] && out_ready[k])
                    void'(q[k].pop_front());
            end
        end
    end

    // One clock: observe the handshake, then apply the spec's effect to the model.
    task automatic step(output logic acc);
        logic            oor;
        logic            r;
        logic [SELW-1:0] s;
        logic [DW-1:0]   d;
        @(negedge clk);
        acc = in_valid & in_ready;
        oor = (int'(in_sel) >= NCH);
        r   = rst;
        s   = in_sel;
        d   = in_data;
        @(posedge clk);
        #1;
        exp_drop = 1'b0;
        if (r) begin
            for (int k = 0; k < NCH; k++) begin
                q[k].delete();
                last[k] = '0;
            end
        end else if (acc) begin
            if (oor)
                exp_drop = 1'b1;
            else begin
                q[s].push_back(d);
                last[s] = d;
            end
        end
    endtask

    task automatic send(input logic [SELW-1:0] s, input logic [DW-1:0] d, input string nm);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        for (int i = 0; i < 40 && !acc; i++) step(acc);
        chk(nm, 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NCH; k++) last[k] = '0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_sel    = 3'd2;
        in_data   = 8'h5A;
        out_ready = '1;
        step(a);
        mon_en = 1'b1;

        // Reset held with traffic present
        repeat (3) begin
            step(a);
            chk("rst_no_accept", 64'(a), 64'd0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Single route
        send(3'd5, 8'hA5, "route_accept");
        chk("route_valid", 64'(out_valid), 64'(6'b10_0000));
        chk("route_data", 64'(out_data[5*DW +: DW]), 64'h00A5);
        step(a);

        // Backpressure on channel 2 while channel 3 still flows
        out_ready = 6'b11_1011;
        send(3'd2, 8'h11, "bp_first");
        send(3'd3, 8'h33, "bp_other_chan");
        in_valid = 1'b1;
        in_sel   = 3'd2;
        in_data  = 8'h22;
        repeat (3) begin
            step(a);
            chk("bp_stall", 64'(a), 64'd0);
        end
        out_ready[2] = 1'b1;
        step(a);
        chk("bp_accept", 64'(a), 64'd1);
        in_valid = 1'b0;
        repeat (2) step(a);

        // Back-to-back streaming, selects 6 and 7 fall out of range
        out_ready = '1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_sel   = 3'(i % 8);
            in_data  = 8'($urandom);
            step(a);
            chk("stream_accept", 64'(a), 64'd1);
        end
        in_valid = 1'b0;
        step(a);

        // Out-of-range word
        in_valid = 1'b1;
        in_sel   = 3'd7;
        in_data  = 8'h3C;
        step(a);
        in_valid = 1'b0;
        chk("oor_accept", 64'(a), 64'd1);
        chk("oor_drop", 64'(drop_err), 64'd1);
        chk("oor_no_valid", 64'(out_valid), 64'd0);
        step(a);
        chk("oor_drop_clear", 64'(drop_err), 64'd0);

        // Random traffic with occasional reset, producer holds stalled words
        a = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (!(in_valid && !a)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 3'($urandom_range(0, 7));
                in_data  = 8'($urandom);
            end
            out_ready = 6'($urandom);
            rst       = ($urandom_range(0, 199) == 0);
            step(a);
        end

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = '1;
        repeat (3) step(a);
        for (int k = 0; k < NCH; k++)
            chk($sformatf("drain[%0d]", k), 64'(q[k].size()), 64'd0);
        chk("drain_valid", 64'(out_valid), 64'd0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/demux_1_n_stream.md
Name: demux_1_n_stream

Overview:
Parametrised successor to the team's registered 1:8 demux. Routes one valid/ready input stream of DW-bit words to one of NCH output channels, selected by in_sel. Each channel has a one-entry output register with its own valid/ready handshake, so one stalled channel does not block traffic to other channels. Out-of-range selects are flagged rather than silently lost. Sits between a single producer and NCH independent consumers.

Parameters:
NCH, 8, number of output channels; must be >= 2.
DW, 1, data width in bits per word.
SELW, $clog2(NCH), select width; derived localparam, not user-overridable.

Ports:
clk  input  1  clock, all logic on the rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  producer has a word
in_ready  output  1  block accepts the word this cycle
in_data  input  DW  input word
in_sel  input  SELW  target channel index
out_valid  output  NCH  per-channel word held
out_ready  input  NCH  per-channel consumer accepts
out_data  output  NCH*DW  channel k occupies bits [k*DW +: DW]
drop_err  output  1  one-cycle pulse: a word with in_sel >= NCH was dropped

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, every out_data=0, drop_err=0. in_ready is forced to 0 while rst=1.
- Reset mid-operation: all held words are discarded. No partial state survives.
- Channel k is loadable when (~out_valid[k] | out_ready[k]).
- in_ready is combinational and depends on in_sel:
  - in_sel < NCH: in_ready = loadable(in_sel).
  - in_sel >= NCH: in_ready = 1 (sink the word).
- Transfer: in_valid & in_ready at edge t. If in_sel < NCH, then at t+1 out_valid[in_sel]=1 and out_data[in_sel]=in_data.
- Latency: 1 cycle, input to output.
- Each channel sustains 1 word/cycle: a full channel with out_ready=1 in the same cycle as a new load is drained and reloaded. out_valid stays 1 and the data updates.
- A channel with out_valid=1 and out_ready=0 holds its data stable until accepted.
- out_valid[k] clears at the edge where out_ready[k]=1 and no new load targets k.
- out_data[k] keeps its last value when out_valid[k]=0. Consumers must qualify with out_valid.
- Non-selected channels are never modified by a transfer.
- Out-of-range select (only possible when NCH is not a power of 2): the accepted word is discarded, and drop_err=1 for exactly the following cycle.
- in_valid=0: no state change except channel drains. in_sel and in_data are don't-care.
- Producer rule: once in_valid=1 with in_ready=0, in_data and in_sel must hold until the transfer completes. The block itself does not check this.

Optional Feature:
Macro DEMUX_BCAST_EN.
- Defined: adds input in_bcast (1 bit).
  - When in_valid & in_bcast: in_sel is ignored, and in_ready = AND of loadable(k) over all k.
  - On transfer, every channel loads in_data and sets out_valid at t+1.
  - drop_err is never raised for broadcast words.
- Not defined: the port is absent, and behaviour is exactly as above.

Decomposition:
- Package demux_pkg: sel_width(n) function (minimum 1), and the default NCH/DW constants.
- Sub-module demux_chan_reg: one-entry valid/ready register. Ports: clk, rst, load, ld_data, out_ready, out_valid, out_data, loadable.
- The top level instantiates NCH copies via generate and contains the select decode, in_ready mux and drop_err register.

Test Plan:
- Reset: drive rst=1 with traffic present -> out_valid=0, out_data all 0, in_ready=0, drop_err=0; release -> in_ready=1.
- Single route: NCH=8, DW=8, in_sel=5, in_data=0xA5, all out_ready=1 -> next cycle out_valid=8'b0010_0000 and out_data[5]=0xA5; other channels unchanged.
- Backpressure: out_ready[2]=0, send 0x11 then 0x22 to ch2 -> 0x11 held, in_ready=0 for the second word; raise out_ready[2] -> 0x22 appears the following cycle with no loss. Meanwhile a word to ch3 passes.
- Streaming: out_ready all 1, send 16 back-to-back words cycling in_sel 0..7 -> in_ready stays 1; each word appears on its channel exactly 1 cycle later.
- Out-of-range: NCH=6, in_sel=7, in_data=0x3C -> in_ready=1, no out_valid change, drop_err=1 for one cycle.
- Broadcast (DEMUX_BCAST_EN): out_ready[4]=0 with ch4 full, in_bcast=1 -> in_ready=0; release ch4 -> all 8 channels show the data next cycle.
